m_mem_port_arbiter: RTL
=======================

Name: m_mem_port_arbiter

Overview:
- Shares the core's single memory bus port between instruction fetch (IF) and the load/store unit (LSU).
- Sits between the fetch stage / LSU and the memory/bus interface.
- Generates the lsu_ack pulse that the hazard unit uses to release its LSU stall.
- Priority is LSU first, with a starvation guard for IF. Flushes and PC redirects are absorbed so that stale responses are never delivered.

Parameters:
- STARVE_MAX, 4: consecutive LSU grants with IF pending, after which IF wins the next arbitration.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- if_req_i  in  1  fetch request; level, held until if_ack_o or flush
- if_addr_i  in  AW  fetch address
- if_flush_i  in  1  PC redirect (PC_changed); kills the pending or in-flight fetch
- if_ack_o  out  1  one-cycle fetch-complete pulse
- if_rdata_o  out  DW  fetch data, valid with if_ack_o
- lsu_req_i  in  1  LSU request; level, held until lsu_ack_o or flush
- lsu_we_i  in  1  1 = store
- lsu_addr_i  in  AW  data address
- lsu_wdata_i  in  DW  store data
- lsu_be_i  in  DW/8  byte enables
- lsu_flush_i  in  1  pipeline flush (lsu_flush_o); kills the pending LSU request or an in-flight load response
- lsu_ack_o  out  1  one-cycle LSU-complete pulse
- lsu_rdata_o  out  DW  load data, valid with lsu_ack_o
- mem_req_o  out  1  bus request; held until mem_ack_i
- mem_we_o  out  1  bus write
- mem_addr_o  out  AW  bus address
- mem_wdata_o  out  DW  bus write data
- mem_be_o  out  DW/8  bus byte enables; forced all-ones for fetches
- mem_ack_i  in  1  bus completion; one cycle; read data valid in the same cycle
- mem_rdata_i  in  DW  bus read data

Behaviour:
- Reset: the following are 0 or cleared: state=IDLE, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, if_ack_o, lsu_ack_o, starve_cnt, discard.
- States: IDLE, IF_BUSY, LSU_BUSY. State and all mem_* outputs are registered.
- Arbitration in IDLE:
  - Valid requests are lsu_req_i&~lsu_flush_i and if_req_i&~if_flush_i.
  - Both valid: grant LSU unless starve_cnt==STARVE_MAX, in which case grant IF.
  - Request fields are latched into the mem_* registers. mem_req_o rises the cycle after acceptance (1-cycle request latency).
- starve_cnt:
  - +1 on each LSU grant while IF is valid; saturates at STARVE_MAX.
  - Cleared on any IF grant.
  - Cleared on an LSU grant with IF not requesting.
- Busy states: mem_* are held stable until mem_ack_i. On mem_ack_i: mem_req_o drops in the next cycle, and state returns to IDLE.
- Acks: if_ack_o / lsu_ack_o = mem_ack_i & (state matches) & ~discard. This is combinational, so completion latency is zero cycles. rdata is passed straight through from mem_rdata_i.
- Minimum occupancy is 2 cycles per transaction. Back-to-back grants take at least 1 IDLE cycle between them.
- Flush while busy:
  - if_flush_i in IF_BUSY, or lsu_flush_i in LSU_BUSY with mem_we_o=0, sets discard.
  - The bus transaction still runs to mem_ack_i, because a bus request is never retracted. The ack is suppressed and discard clears on mem_ack_i.
  - Flush in the same cycle as mem_ack_i also suppresses the ack.
- In-flight stores are never discarded: the store completes and lsu_ack_o is delivered even if lsu_flush_i is asserted.
- Flush in IDLE blocks acceptance of that requester in that cycle only. The other requester is still arbitrated.
- A requester that drops its request while granted has no effect. Transactions are committed once granted.
- rst in any state aborts immediately and returns to reset values. The bus slave must tolerate a dropped request on reset.
- No combinational path exists from any *_req_i to mem_req_o.

Decomposition:
- Shared core package gets:
  - typedef enum arb_state_e {IDLE, IF_BUSY, LSU_BUSY}
  - struct mem_req_t {we, addr, wdata, be}
  - constant BE_ALL.
- One sub-module, m_starve_counter: saturating counter with inc/clr/sat flag. Everything else stays flat.

Test Plan:
- Single fetch: if_req_i=1, addr 0x0000_0100, mem_ack_i 3 cycles after mem_req_o with rdata 0x0000_0013 -> mem_be_o=0xF, if_ack_o pulses 1 cycle with rdata 0x13, lsu_ack_o=0.
- Simultaneous: both requests rise in the same cycle, 1-cycle bus -> LSU is served first. IF is granted after 1 IDLE cycle with its address on mem_addr_o.
- Starvation: IF held high, LSU re-requests continuously, STARVE_MAX=4 -> grant order is LSU, LSU, LSU, LSU, IF, then starve_cnt=0.
- Fetch flush: if_flush_i asserted 1 cycle after mem_req_o, ack arrives 2 cycles later -> no if_ack_o. The next fetch to 0x200 is accepted and acked normally.
- Store under flush: store to 0x8000_0000, be=0x3, lsu_flush_i asserted mid-transaction -> mem_we_o=1 held until ack, lsu_ack_o pulses. A load under the same flush gets no lsu_ack_o.
- Reset: rst asserted in LSU_BUSY -> next cycle state=IDLE, mem_req_o=0, starve_cnt=0. A mem_ack_i arriving afterwards produces no ack pulse.

Source files
------------

// File: rtl/m_mem_port_arbiter_pkg.sv
// m_mem_port_arbiter_pkg
// Shared types for the memory port arbiter: the arbiter FSM state, a bundle
// describing one bus request, and the all-ones byte-enable used for fetches.
package m_mem_port_arbiter_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    LSU_BUSY = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_AW-1:0]     addr;
    logic [MEM_DW-1:0]     wdata;
    logic [MEM_DW/8-1:0]   be;
  } mem_req_t;

  // Fetches always read a full word.
  localparam logic [MEM_DW/8-1:0] BE_ALL = '1;

endpackage

// File: rtl/m_mem_port_arbiter_starve.sv
// m_starve_counter
// Saturating counter that tracks how many times the LSU has been granted
// while a fetch was waiting. 'sat' tells the arbiter to let IF win next.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   inc      : count one more starved arbitration (held at MAX once saturated)
//   clr      : return to zero (wins over inc)
//   cnt      : current count
//   sat      : cnt == MAX
// MAX must be at least 1.
module m_starve_counter #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && !sat) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
  assign sat = (cnt_reg == CW'(MAX));

endmodule

// File: rtl/m_mem_port_arbiter.sv
// m_mem_port_arbiter
// Shares the single memory bus port between instruction fetch (IF) and the
// load/store unit (LSU). LSU has priority; after STARVE_MAX LSU wins with IF
// waiting, IF takes the next arbitration. Flushed loads/fetches still finish
// on the bus (a request is never retracted) but their ack is swallowed.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   if_req_i/if_addr_i/if_flush_i : fetch request, address, PC redirect
//   if_ack_o/if_rdata_o           : fetch completion pulse and data
//   lsu_req_i/we/addr/wdata/be    : LSU request and its fields
//   lsu_flush_i                   : pipeline flush (loads only are killed)
//   lsu_ack_o/lsu_rdata_o         : LSU completion pulse and load data
//   mem_*_o                       : registered bus request, held until ack
//   mem_ack_i/mem_rdata_i         : one-cycle bus completion and read data
module m_mem_port_arbiter
  import m_mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  input  logic            if_flush_i,
  output logic            if_ack_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [AW-1:0]   lsu_addr_i,
  input  logic [DW-1:0]   lsu_wdata_i,
  input  logic [DW/8-1:0] lsu_be_i,
  input  logic            lsu_flush_i,
  output logic            lsu_ack_o,
  output logic [DW-1:0]   lsu_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_be_o,
  input  logic            mem_ack_i,
  input  logic [DW-1:0]   mem_rdata_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_reg;
  logic          discard_reg;
  logic          if_valid;
  logic          lsu_valid;
  logic          grant_if;
  logic          grant_lsu;
  logic          starve_inc;
  logic          starve_clr;
  logic          starve_sat;
  logic [CW-1:0] starve_cnt;
  logic          kill_if;
  logic          kill_lsu;

  always_comb begin
    if_valid  = if_req_i & ~if_flush_i;
    lsu_valid = lsu_req_i & ~lsu_flush_i;

    grant_if  = (state_reg == IDLE) & if_valid & (~lsu_valid | starve_sat);
    grant_lsu = (state_reg == IDLE) & lsu_valid & ~grant_if;

    // Only LSU wins that beat a waiting fetch count as starvation.
    starve_inc = grant_lsu & if_valid;
    starve_clr = grant_if | (grant_lsu & ~if_valid);

    // Stores in flight are committed; only loads and fetches can be killed.
    kill_if  = (state_reg == IF_BUSY) & if_flush_i;
    kill_lsu = (state_reg == LSU_BUSY) & lsu_flush_i & ~mem_we_o;

    // A flush landing in the ack cycle must also swallow the ack.
    if_ack_o  = ~rst & mem_ack_i & (state_reg == IF_BUSY) & ~discard_reg & ~kill_if;
    lsu_ack_o = ~rst & mem_ack_i & (state_reg == LSU_BUSY) & ~discard_reg & ~kill_lsu;

    if_rdata_o  = mem_rdata_i;
    lsu_rdata_o = mem_rdata_i;
  end

  m_starve_counter #(
    .MAX (STARVE_MAX),
    .CW  (CW)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .cnt (starve_cnt),
    .sat (starve_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      discard_reg <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_if) begin
            state_reg   <= IF_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            mem_be_o    <= '1;
          end else if (grant_lsu) begin
            state_reg   <= LSU_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= lsu_we_i;
            mem_addr_o  <= lsu_addr_i;
            mem_wdata_o <= lsu_wdata_i;
            mem_be_o    <= lsu_be_i;
          end
        end
        default: begin
          // Busy: bus fields stay frozen until the slave completes.
          if (mem_ack_i) begin
            state_reg   <= IDLE;
            mem_req_o   <= 1'b0;
            discard_reg <= 1'b0;
          end else if (kill_if || kill_lsu) begin
            discard_reg <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
